// File: rtl/fmap_stim_gen_pkg.sv
// Shared types for the feature-map stimulus generator: pattern modes, FSM states
// and the per-frame configuration latched at start.
package fmap_stim_gen_pkg;

   localparam int unsigned SEL_W = 12;
   localparam int unsigned K_W   = 16;

   typedef enum logic [1:0] {
      MODE_RAMP   = 2'd0,
      MODE_CONST  = 2'd1,
      MODE_POKE   = 2'd2,
      MODE_BEATID = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_FIN  = 2'd3
   } state_e;

   typedef struct packed {
      mode_e            mode;
      logic [7:0]       seed;
      logic [SEL_W-1:0] sel;
      logic [7:0]       poke_val;
   } cfg_t;

endpackage

// File: rtl/fmap_pattern_lane.sv
// One payload byte: maps the flat byte index k (and its beat id) to a pattern byte.
module fmap_pattern_lane
   import fmap_stim_gen_pkg::*;
(
   input  logic [K_W-1:0]   k_i,
   input  logic [7:0]       beat_i,
   input  mode_e            mode_i,
   input  logic [7:0]       seed_i,
   input  logic [SEL_W-1:0] sel_i,
   input  logic [7:0]       poke_val_i,
   output logic [7:0]       byte_c_o
);

   always_comb begin
      byte_c_o = '0;
      unique case (mode_i)
         MODE_RAMP:   byte_c_o = seed_i + k_i[7:0];
         MODE_CONST:  byte_c_o = seed_i;
         MODE_POKE:   byte_c_o = (k_i == K_W'(sel_i)) ? poke_val_i : 8'h00;
         MODE_BEATID: byte_c_o = beat_i;
         default:     byte_c_o = '0;
      endcase
   end

endmodule

// File: rtl/fmap_stim_gen.sv
// Frame stimulus generator: streams BEATS_PER_FRAME beats of a selectable byte
// pattern over a valid/ready interface, with optional idle gaps between beats.
module fmap_stim_gen
   import fmap_stim_gen_pkg::*;
#(
   parameter int unsigned BYTES_PER_BEAT  = 40,
   parameter int unsigned BEATS_PER_FRAME = 64,
   parameter int unsigned GAP             = 0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [1:0]                  mode,
   input  logic [7:0]                  seed,
   input  logic [SEL_W-1:0]            sel,
   input  logic [7:0]                  poke_val,
   input  logic                        ready,
   output logic [8*BYTES_PER_BEAT-1:0] data_o,
   output logic                        valid_o,
   output logic                        last_o,
   output logic                        busy,
   output logic                        done
);

   localparam int unsigned B_W   = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned DW    = 8 * BYTES_PER_BEAT;
   localparam logic [B_W-1:0] B_LAST = B_W'(BEATS_PER_FRAME - 1);

   state_e           state_q, state_d;
   logic [B_W-1:0]   b_q, b_d;
   logic [CNT_W-1:0] gcnt_q, gcnt_d;
   cfg_t             cfg_q, cfg_d;
   logic [DW-1:0]    data_q, data_d, lane_data_c;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Next state; outputs are computed from the next state so they register in step with it.
   always_comb begin
      state_d = state_q;
      b_d     = b_q;
      gcnt_d  = gcnt_q;
      cfg_d   = cfg_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               cfg_d   = '{mode: mode_e'(mode), seed: seed, sel: sel, poke_val: poke_val};
               b_d     = '0;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (ready) begin
               if (b_q == B_LAST) begin
                  b_d     = '0;
                  state_d = ST_FIN;
               end else begin
                  b_d = B_W'(b_q + 1'b1);
                  if (GAP > 0) begin
                     gcnt_d  = CNT_W'(GAP - 1);
                     state_d = ST_GAP;
                  end
               end
            end
         end
         ST_GAP: begin
            if (gcnt_q == '0) state_d = ST_SEND;
            else              gcnt_d  = CNT_W'(gcnt_q - 1'b1);
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      valid_d = (state_d == ST_SEND);
      data_d  = valid_d ? lane_data_c : '0;
      last_d  = valid_d && (b_d == B_LAST);
      busy_d  = (state_d == ST_SEND) || (state_d == ST_GAP);
      done_d  = (state_d == ST_FIN);
   end

   // Lanes evaluate the beat about to be presented, so a stalled beat recomputes identically.
   for (genvar j = 0; j < BYTES_PER_BEAT; j++) begin : g_lane
      fmap_pattern_lane u_lane (
         .k_i        (K_W'(b_d) * K_W'(BYTES_PER_BEAT) + K_W'(j)),
         .beat_i     (8'(b_d)),
         .mode_i     (cfg_d.mode),
         .seed_i     (cfg_d.seed),
         .sel_i      (cfg_d.sel),
         .poke_val_i (cfg_d.poke_val),
         .byte_c_o   (lane_data_c[8*j +: 8])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         b_q     <= '0;
         gcnt_q  <= '0;
         cfg_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         b_q     <= b_d;
         gcnt_q  <= gcnt_d;
         cfg_q   <= cfg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign last_o  = last_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: doc/fmap_stim_gen.md
FMAP_STIM_GEN -- requirements
Module: fmap_stim_gen

Interface
REQ-001 SHALL have parameter BYTES_PER_BEAT, default 40, bytes per output beat.
REQ-002 SHALL have parameter BEATS_PER_FRAME, default 64, beats per frame.
REQ-003 SHALL have parameter GAP, default 0, idle cycles inserted after each accepted beat.
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle frame request.
REQ-007 SHALL have port mode  input  2  pattern select, latched at start.
REQ-008 SHALL have port seed  input  8  pattern base value, latched at start.
REQ-009 SHALL have port sel  input  12  flat byte index for poke mode, latched at start.
REQ-010 SHALL have port poke_val  input  8  poke byte value, latched at start.
REQ-011 SHALL have port ready  input  1  downstream accept.
REQ-012 SHALL have port data_o  output  8*BYTES_PER_BEAT  beat payload; byte j at bits [8j+7:8j].
REQ-013 SHALL have port valid_o  output  1  beat valid.
REQ-014 SHALL have port last_o  output  1  final beat of frame, qualified by valid_o.
REQ-015 SHALL have port busy  output  1  frame in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-017 SHALL implement FSM states IDLE, SEND, GAP, FIN.
REQ-018 IDLE: on start, SHALL latch mode/seed/sel/poke_val, clear beat counter b=0, go to SEND; valid_o first high the cycle after start.
REQ-019 SEND: valid_o=1; a beat is accepted when valid_o && ready.
REQ-020 SEND: while valid_o && !ready, data_o, last_o and b SHALL hold stable.
REQ-021 On accept with b<BEATS_PER_FRAME-1: b increments; next state GAP if GAP>0, else SEND (back-to-back beats).
REQ-022 On accept with b==BEATS_PER_FRAME-1: next state FIN; b wraps to 0.
REQ-023 GAP: valid_o=0 for exactly GAP cycles, then SEND.
REQ-024 FIN: done=1 for one cycle, busy=0 that cycle, next state IDLE.
REQ-025 last_o SHALL equal (b==BEATS_PER_FRAME-1) while in SEND, else 0.
REQ-026 busy SHALL be 1 in SEND and GAP, 0 in IDLE and FIN.
REQ-027 start while busy or in FIN SHALL be ignored; latched configuration unchanged.
REQ-028 Flat index of byte j in beat b: k = b*BYTES_PER_BEAT + j.
REQ-029 mode 0 (ramp): byte = (seed + k) mod 256.
REQ-030 mode 1 (const): every byte = seed.
REQ-031 mode 2 (poke): byte = poke_val where k==sel, else 0; sel >= BYTES_PER_BEAT*BEATS_PER_FRAME yields an all-zero frame.
REQ-032 mode 3 (beat id): every byte = b mod 256.
REQ-033 data_o SHALL be registered; combinational input-to-output paths are not permitted.
REQ-034 data_o SHALL be 0 whenever valid_o is 0.

Reset
REQ-035 On rst_n low: state IDLE; b=0; data_o, valid_o, last_o, busy, done = 0; latched config = 0.
REQ-036 Reset mid-frame SHALL abort the frame; no done pulse; the next start begins again at b=0.

Structure
REQ-037 Mode encodings (RAMP=0, CONST=1, POKE=2, BEATID=3) and FSM state encodings SHALL reside in the shared CNN package.
REQ-038 Sub-module fmap_pattern_lane (one byte: k, mode, seed, sel, poke_val -> byte) SHALL be instantiated BYTES_PER_BEAT times.

Verification
REQ-039 Defaults; mode 0, seed 8'hF0, ready=1 -> 64 consecutive beats; beat0 byte0=F0, byte15=FF, byte16=00; beat1 byte0=18; last_o on beat 63 only; done one cycle after the beat-63 accept.
REQ-040 Mode 2, sel=85, poke_val=8'hA5 -> beat 2 byte 5 = A5; all other 2559 bytes = 0.
REQ-041 Mode 1, seed 8'h3C, ready low for 3 cycles at beat 10 -> data_o and last_o stable; beat 10 is delivered exactly once; total 64 beats.
REQ-042 GAP=2, mode 3 -> valid_o pattern 1,0,0 repeating; beat n bytes = n; frame spans 190 cycles with ready=1.
REQ-043 Second start pulse at beat 5, with different seed -> ignored; frame completes with original seed; one done pulse.
REQ-044 rst_n low at beat 30 -> all outputs 0 and no done pulse; a new start yields beat 0 with last_o=0.
